serial_subtractor: RTL and testbench

//  Bit-serial WIDTH-bit subtractor: D = A - B, one bit per clock, LSB first, via a single

---
 rtl/serial_subtractor.sv | 159 +++++++++++++++
 tb/tb_serial_subtractor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B, LSB first, one full-subtractor cell plus a borrow flop.
// Latency: done pulses in the cycle after edge k+WIDTH (accept edge k); one op per WIDTH+2 cycles.
// Backpressure: start is sampled only in IDLE; starts in SHIFT/DONE are dropped, never queued.
// Optional build macro SERIAL_SUB_SATURATE_EN: clamp D to 0 when the final borrow is set.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  // Bit counter only has to reach WIDTH-1.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Control strobes decoded from the current state.
  logic accept;
  logic shift_en;
  logic last_bit;

  // Datapath registers.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;

  // Full-subtractor cell working on the current LSBs.
  logic a_bit;
  logic b_bit;
  logic d_bit;
  logic br_next;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> SHIFT on start, SHIFT -> DONE after the last bit, DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)    state_d = S_SHIFT;
      S_SHIFT: if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and strobe decode from the registered state.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      S_IDLE:  accept   = start;
      S_SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
      end
      S_DONE:  done     = 1'b1;
      default: ;
    endcase
  end

  assign last_bit = shift_en && (cnt_q == LAST_BIT);

  // One bit of A - B with incoming borrow br_q.
  always_comb begin
    a_bit   = a_q[0];
    b_bit   = b_q[0];
    d_bit   = a_bit ^ b_bit ^ br_q;
    br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
  end

  // Operand shift registers, bit counter and running borrow.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    br_d  = br_q;
    if (accept) begin
      a_d   = A;
      b_d   = B;
      cnt_d = '0;
      br_d  = 1'b0;
    end else if (shift_en) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + CW'(1);
      br_d  = br_next;
    end
  end

  // Result register: cleared on accept, filled from the MSB side, held after completion.
  always_comb begin
    diff_d   = diff_q;
    borrow_d = borrow_q;
    if (accept) begin
      diff_d   = '0;
      borrow_d = 1'b0;
    end else if (shift_en) begin
      diff_d = {d_bit, diff_q[WIDTH-1:1]};
      if (last_bit) begin
        borrow_d = br_next;
`ifdef SERIAL_SUB_SATURATE_EN
        // Negative result clamps to zero; the borrow still reports the underflow.
        if (br_next) begin
          diff_d = '0;
        end
`endif
      end
    end
  end

  // Datapath flops; async reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign D          = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=4.
// Table vectors, random operands against an arithmetic model, and multi-cycle corner sequences.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] D;
  logic         borrow_out;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .A          (A),
    .B          (B),
    .D          (D),
    .borrow_out (borrow_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         br;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Clamp expected difference when the saturating build is selected.
  function automatic logic [W-1:0] sat_adj(input logic [W-1:0] d, input logic br);
`ifdef SERIAL_SUB_SATURATE_EN
    return br ? '0 : d;
`else
    return d;
`endif
  endfunction

  // Reference: plain integer subtraction modulo 2^W and unsigned compare.
  function automatic logic [W-1:0] model_d(input int a, input int b);
    int r;
    r = (a - b + (1 << W)) % (1 << W);
    return sat_adj(W'(r), (a < b) ? 1'b1 : 1'b0);
  endfunction

  // Run one operation: start pulse, scramble operands after accept, wait for done.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] d, output logic br,
                       output int bcnt, output int lat,
                       output logic [W-1:0] d1, output logic br1);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom); B = W'($urandom);
    bcnt = 0; lat = 0; d = '0; br = 1'b0;
    d1 = D; br1 = borrow_out;
    for (int i = 1; i <= 20; i++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = i; d = D; br = borrow_out;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_d, input logic exp_br);
    logic [W-1:0] d, d1;
    logic br, br1;
    int bcnt, lat;
    do_op(a, b, d, br, bcnt, lat, d1, br1);
    check({tag, " D_cleared_at_accept"}, int'(d1), 0);
    check({tag, " borrow_cleared_at_accept"}, int'(br1), 0);
    check({tag, " done_latency"}, lat, W + 1);
    check({tag, " busy_cycles"}, bcnt, W);
    check({tag, " D"}, int'(d), int'(exp_d));
    check({tag, " borrow_out"}, int'(br), int'(exp_br));
    @(negedge clk);
    check({tag, " done_single_pulse"}, int'(done), 0);
    check({tag, " D_held"}, int'(D), int'(exp_d));
    check({tag, " borrow_held"}, int'(borrow_out), int'(exp_br));
  endtask

  vec_t vecs[8];

  initial begin
    int ndone;
    int first_done;
    int second_done;
    logic [W-1:0] ra, rb;
    logic [W-1:0] d2;
    logic br2;

    start = 1'b0; A = '0; B = '0; rst_n = 1'b0;

    vecs[0] = '{a: 4'd9,  b: 4'd3,  d: 4'd6,  br: 1'b0};
    vecs[1] = '{a: 4'd3,  b: 4'd9,  d: 4'd10, br: 1'b1};
    vecs[2] = '{a: 4'd15, b: 4'd15, d: 4'd0,  br: 1'b0};
    vecs[3] = '{a: 4'd0,  b: 4'd15, d: 4'd1,  br: 1'b1};
    vecs[4] = '{a: 4'd8,  b: 4'd1,  d: 4'd7,  br: 1'b0};
    vecs[5] = '{a: 4'd0,  b: 4'd0,  d: 4'd0,  br: 1'b0};
    vecs[6] = '{a: 4'd15, b: 4'd0,  d: 4'd15, br: 1'b0};
    vecs[7] = '{a: 4'd1,  b: 4'd2,  d: 4'd15, br: 1'b1};

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset D", int'(D), 0);
    check("reset borrow_out", int'(borrow_out), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    rst_n = 1'b1;

    // Table vectors.
    for (int i = 0; i < 8; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                sat_adj(vecs[i].d, vecs[i].br), vecs[i].br);
    end

    // Random operands against the model.
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_check($sformatf("rnd%0d", i), ra, rb, model_d(int'(ra), int'(rb)),
                (ra < rb) ? 1'b1 : 1'b0);
    end

    // Start while busy is ignored: A=8,B=1 then a pulse with A=0,B=1 two cycles later.
    @(negedge clk);
    A = 4'd8; B = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 4'd0; B = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; d2 = '0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        ndone++;
        d2 = D;
      end
      @(negedge clk);
    end
    check("ignored_start done_count", ndone, 1);
    check("ignored_start D", int'(d2), 7);
    check("ignored_start idle", int'(busy), 0);

    // Back-to-back with start held high: second op uses operands present at its accept.
    @(negedge clk);
    A = 4'd5; B = 4'd2; start = 1'b1;
    first_done = 0; second_done = 0; d2 = '0; br2 = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (done && first_done == 0) begin
        first_done = i;
        check("b2b first D", int'(D), 3);
        A = 4'd7; B = 4'd9;
      end else if (done && second_done == 0) begin
        second_done = i;
        d2 = D; br2 = borrow_out;
      end
    end
    start = 1'b0;
    check("b2b first_done", first_done, W + 1);
    check("b2b period", second_done - first_done, W + 2);
    check("b2b second D", int'(d2), int'(sat_adj(4'd14, 1'b1)));
    check("b2b second borrow", int'(br2), 1);
    repeat (8) @(negedge clk);

    // Async reset mid-operation aborts with no done, then a fresh op runs normally.
    @(negedge clk);
    A = 4'd12; B = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort D", int'(D), 0);
    check("abort borrow_out", int'(borrow_out), 0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no_done", ndone, 0);
    rst_n = 1'b1;
    run_check("after_abort", 4'd12, 4'd5, 4'd7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
